alu_share_arbiter: RTL and testbench

//  Shares the single-cycle ALU between two requesters (e.g. main datapath and address/branch unit).
//  - Round-robin 2-way arbitration; valid/ready handshake on each request and response port.
//  - Registers the granted operands, drives them to the ALU, captures ALUOut/Zero, returns the result to the winner.
//  - Holds MULTIPLICATION (sel 4'b1011) in EXEC for MUL_LAT cycles.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 13 +
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU select codes and arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SRA  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLLV = 4'd8;
    localparam logic [3:0] ALU_SRLV = 4'd9;
    localparam logic [3:0] ALU_SRAV = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant; rr_ptr names the winner on a tie.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = valid0 & (~valid1 | ~rr_ptr);
    assign gnt1 = valid1 & (~valid0 |  rr_ptr);

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one single-cycle ALU between two requesters: arbitrate, issue
// registered operands, capture the result and hand it back to the winner.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SEL_W   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [4:0]       req0_shamt,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic [4:0]       req1_shamt,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [SEL_W-1:0] alu_sel,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t           state, state_nxt;
    logic             rr_ptr, owner;
    logic [CNT_W-1:0] cnt;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [SEL_W-1:0] g_sel;

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .rr_ptr (rr_ptr),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    assign g_sel = gnt1 ? req1_sel : req0_sel;

    // Both responders see the one capture register; only the owner's valid rises.
    assign rsp0_result = res;
    assign rsp1_result = res;
    assign rsp0_zero   = zero;
    assign rsp1_zero   = zero;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                // rst_n gate keeps ready low while reset is held with a request pending
                req0_ready = rst_n & gnt0;
                req1_ready = rst_n & gnt1;
                if (gnt0 | gnt1) state_nxt = EXEC;
            end
            EXEC: if (cnt == '0) state_nxt = RESP;
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid =  owner;
                if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_sel   <= '0;
            alu_shamt <= '0;
            res       <= '0;
            zero      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (gnt0 | gnt1)) begin
                owner     <= gnt1;
                rr_ptr    <= ~gnt1;
                alu_in1   <= gnt1 ? req1_a : req0_a;
                alu_in2   <= gnt1 ? req1_b : req0_b;
                alu_sel   <= g_sel;
                alu_shamt <= gnt1 ? req1_shamt : req0_shamt;
                cnt       <= (g_sel == SEL_W'(ALU_MUL)) ? CNT_W'(MUL_LAT - 1) : '0;
            end else if (state == EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    res  <= alu_out;
                    zero <= alu_zero;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a behavioural ALU alongside it.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32, SEL_W = 4, MUL_LAT = 2;

    logic clk, rst_n;
    logic req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
    logic [3:0]  req0_sel, req1_sel, alu_sel;
    logic [4:0]  req0_shamt, req1_shamt, alu_shamt;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_zero;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .req0_shamt(req0_shamt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .req1_shamt(req1_shamt),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_shamt(alu_shamt),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] sel, input logic [4:0] sh);
        logic [31:0] r;
        r = '0;
        case (sel)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ADD:  r = a + b;
            ALU_SLL:  r = b << sh;
            ALU_SRL:  r = b >> sh;
            ALU_SRA:  r = $signed(b) >>> sh;
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLLV: r = b << a[4:0];
            ALU_SRLV: r = b >> a[4:0];
            ALU_SRAV: r = $signed(b) >>> a[4:0];
            ALU_MUL:  r = a * b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_out  = alu_ref(alu_in1, alu_in2, alu_sel, alu_shamt);
        alu_zero = (alu_out == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0; req0_shamt = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0; req1_shamt = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] s, input logic [4:0] sh);
        req0_valid = v; req0_a = a; req0_b = b; req0_sel = s; req0_shamt = sh;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] s, input logic [4:0] sh);
        req1_valid = v; req1_a = a; req1_b = b; req1_sel = s; req1_shamt = sh;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        set_req0(1, 5, 3, ALU_ADD, 0);
        repeat (3) begin
            tick();
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_handshake: got %b want 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
            end
            checks++;
            if (alu_in1 !== 32'd0 || rsp0_result !== 32'd0) begin
                errors++;
                $display("FAIL reset_data: alu_in1=%0h rsp0_result=%0h want 0", alu_in1, rsp0_result);
            end
        end
        rst_n = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 0;
    endtask

    task automatic test_single();
        reset_dut();
        set_req0(1, 5, 3, ALU_ADD, 0);
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", req0_ready); end
        tick();
        req0_valid = 0;
        checks++;
        if (rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL single_exec: rsp0_valid=%b req0_ready=%b want 0 0", rsp0_valid, req0_ready);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd8 || rsp0_zero !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: valid=%b result=%0h zero=%b rsp1_valid=%b want 1 8 0 0",
                     rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_done: rsp0_valid=%b want 0", rsp0_valid); end
    endtask

    task automatic test_contention();
        // per cycle: {req0_ready, req1_ready, rsp0_valid, rsp1_valid}
        logic [3:0] expv [7] = '{4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b1000};
        reset_dut();
        set_req0(1, 7, 7, ALU_SUB, 0);
        set_req1(1, 32'hF0, 32'h0F, ALU_OR, 0);
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== expv[c]) begin
                errors++;
                $display("FAIL contention_c%0d: got %b want %b", c,
                         {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, expv[c]);
            end
            if (c == 2) begin
                checks++;
                if (rsp0_result !== 32'd0 || rsp0_zero !== 1'b1) begin
                    errors++; $display("FAIL contention_sub: result=%0h zero=%b want 0 1", rsp0_result, rsp0_zero);
                end
            end
            if (c == 5) begin
                checks++;
                if (rsp1_result !== 32'hFF || rsp1_zero !== 1'b0) begin
                    errors++; $display("FAIL contention_or: result=%0h zero=%b want ff 0", rsp1_result, rsp1_zero);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_mul();
        reset_dut();
        set_req1(1, 6, 7, ALU_MUL, 0);
        rsp1_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL mul_accept: got %b want 1", req1_ready); end
        tick();
        req1_valid = 0;
        checks++;
        if (rsp1_valid !== 1'b0 || alu_sel !== ALU_MUL) begin
            errors++; $display("FAIL mul_t1: rsp1_valid=%b alu_sel=%0d want 0 11", rsp1_valid, alu_sel);
        end
        tick();
        checks++;
        if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL mul_t2: rsp1_valid=%b want 0", rsp1_valid); end
        tick();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd42 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_t3: valid=%b result=%0d rsp0_valid=%b want 1 42 0", rsp1_valid, rsp1_result, rsp0_valid);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        set_req0(1, 10, 20, ALU_ADD, 0);
        set_req1(1, 32'hFF, 32'h0F, ALU_AND, 0);
        rsp0_ready = 0; rsp1_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0;
        tick();
        repeat (5) begin
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd30 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: valid=%b result=%0d req1_ready=%b want 1 30 0", rsp0_valid, rsp0_result, req1_ready);
            end
            tick();
        end
        rsp0_ready = 1;
        tick();
        checks++;
        if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: rsp0_valid=%b req1_ready=%b want 0 1", rsp0_valid, req1_ready);
        end
        tick();
        req1_valid = 0;
        tick();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h0F) begin
            errors++; $display("FAIL bp_req1: valid=%b result=%0h want 1 f", rsp1_valid, rsp1_result);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        set_req0(1, 3, 4, ALU_MUL, 0);
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        tick();
        req0_valid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        repeat (5) begin
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_norsp: rsp0=%b rsp1=%b want 0 0", rsp0_valid, rsp1_valid);
            end
            tick();
        end
        set_req1(1, 1, 1, ALU_ADD, 0);
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL midreset_accept: got %b want 1", req1_ready); end
        tick();
        req1_valid = 0;
        tick();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd2 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: valid=%b result=%0d rsp0=%b want 1 2 0", rsp1_valid, rsp1_result, rsp0_valid);
        end
        idle_inputs();
    endtask

    // Transaction-level model: a grant starts a job due a fixed number of cycles later.
    task automatic test_random();
        bit          busy, owner, rr, g0, g1, ev0, ev1;
        int          due;
        logic [31:0] er;
        bit          v [2];
        logic [31:0] a [2], b [2];
        logic [3:0]  s [2];
        logic [4:0]  sh [2];
        busy = 0; owner = 0; rr = 0; due = 0; er = 0;
        v[0] = 0; v[1] = 0;
        reset_dut();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i]  = 1;
                    a[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    b[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    s[i]  = 4'($urandom_range(0, 13));
                    sh[i] = 5'($urandom_range(0, 31));
                end
            end
            set_req0(v[0], a[0], b[0], s[0], sh[0]);
            set_req1(v[1], a[1], b[1], s[1], sh[1]);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            g0  = !busy && v[0] && (!v[1] || !rr);
            g1  = !busy && v[1] && (!v[0] ||  rr);
            ev0 = busy && cyc >= due && !owner;
            ev1 = busy && cyc >= due &&  owner;
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== {g0, g1, ev0, ev1}) begin
                errors++;
                $display("FAIL rand_hs cyc%0d: got %b want %b", cyc,
                         {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, {g0, g1, ev0, ev1});
            end
            if (ev0 || ev1) begin
                checks++;
                if ((ev0 ? rsp0_result : rsp1_result) !== er || (ev0 ? rsp0_zero : rsp1_zero) !== (er == 32'd0)) begin
                    errors++;
                    $display("FAIL rand_rsp cyc%0d: got %0h/%b want %0h/%b", cyc,
                             ev0 ? rsp0_result : rsp1_result, ev0 ? rsp0_zero : rsp1_zero, er, er == 32'd0);
                end
            end
            tick();
            if (g0 || g1) begin
                busy  = 1;
                owner = g1;
                rr    = !g1;
                due   = cyc + ((s[owner] == ALU_MUL) ? 1 + MUL_LAT : 2);
                er    = alu_ref(a[owner], b[owner], s[owner], sh[owner]);
                v[owner] = 0;
            end else if ((ev0 && rsp0_ready) || (ev1 && rsp1_ready)) begin
                busy = 0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single();
        test_contention();
        test_mul();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
